// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS-subset control FSM.
// State enum, opcode/funct constants, ALU commands and datapath mux selects.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_JR,
        S_JAL,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    localparam logic [1:0] RD_RD = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_IMM  = 2'b00;
    localparam logic [1:0] SRCB_B    = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_A      = 2'b11;

    // ALU command for the supported R-type arithmetic functs
    function automatic logic [2:0] rtype_cmd(input logic [5:0] fn);
        if (fn == FN_SUB) return ALU_SUB;
        if (fn == FN_SLT) return ALU_SLT;
        return ALU_ADD;
    endfunction

endpackage

// File: rtl/ctrl_counters.sv
// Bring-up counters: retired instructions and cycles since reset.
// Both wrap modulo 2^CNT_W.
module ctrl_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    logic [CNT_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;

    // next counter values
    always_comb begin
        instr_d = instr_q;
        cycle_d = cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (retire) instr_d = instr_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            instr_q <= instr_d;
            cycle_q <= cycle_d;
        end
    end

    assign instr_count = instr_q;
    assign cycle_count = cycle_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the single-memory MIPS-subset datapath.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap undecoded instructions in HALT.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             ir_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_cmd,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             mem_we,
    output logic             iord,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    state_t state_q, state_d;
    logic   retire;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // next state and Moore outputs (pc_we in BRANCH also uses zero)
    always_comb begin
        state_d    = S_FETCH;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = RD_RD;
        mem_to_reg = M2R_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_IMM;
        alu_cmd    = ALU_ADD;
        pc_we      = 1'b0;
        pc_src     = PCS_ALU;
        mem_we     = 1'b0;
        iord       = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we     = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_we     = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_RTYPE &&
                    (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT))
                    state_d = S_EXEC_R;
                else if (opcode == OP_RTYPE && funct == FN_JR)
                    state_d = S_JR;
                else if (opcode == OP_LW || opcode == OP_SW)
                    state_d = S_MEM_ADDR;
                else if (opcode == OP_BNE)
                    state_d = S_BRANCH;
                else if (opcode == OP_XORI || opcode == OP_ADDI)
                    state_d = S_EXEC_I;
                else if (opcode == OP_J)
                    state_d = S_JUMP;
                else if (opcode == OP_JAL)
                    state_d = S_JAL;
                else
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_cmd   = rtype_cmd(funct);
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_we = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_cmd   = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                reg_we  = 1'b1;
                reg_dst = RD_RT;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord    = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                reg_dst    = RD_RT;
                mem_to_reg = M2R_MEM;
            end
            S_MEM_WR: begin
                iord   = 1'b1;
                mem_we = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_cmd   = ALU_SUB;
                pc_src    = PCS_ALUOUT;
                pc_we     = ~zero;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = PCS_JUMP;
            end
            S_JR: begin
                pc_we  = 1'b1;
                pc_src = PCS_A;
            end
            S_JAL: begin
                reg_we     = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = M2R_PC;
                pc_we      = 1'b1;
                pc_src     = PCS_JUMP;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            ir_we  = 1'b0;
            reg_we = 1'b0;
            pc_we  = 1'b0;
            mem_we = 1'b0;
        end
    end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    // trap flag while parked in HALT
    always_comb begin
        illegal = (state_q == S_HALT);
    end
`endif

    assign retire = (state_d == S_FETCH) && !reset;

    ctrl_counters #(
        .CNT_W(CNT_W)
    ) u_counters (
        .clk        (clk),
        .reset      (reset),
        .retire     (retire),
        .instr_count(instr_count),
        .cycle_count(cycle_count)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl.
// Reference model is a per-instruction cycle table built from the ISA rules.
module tb_multicycle_ctrl;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       opcode = '0;
    logic [5:0]       funct = '0;
    logic             zero = 1'b0;
    logic             ir_we, reg_we, alu_src_a, pc_we, mem_we, iord;
    logic [1:0]       reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic [2:0]       alu_cmd;
    logic [CNT_W-1:0] instr_count, cycle_count;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic             illegal;
`endif

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_cmd    (alu_cmd),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .mem_we     (mem_we),
        .iord       (iord),
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        .illegal    (illegal),
`endif
        .instr_count(instr_count),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int ecyc = 0;
    int einst = 0;

    logic [16:0] ctl;
    assign ctl = {ir_we, reg_we, reg_dst, mem_to_reg, alu_src_a,
                  alu_src_b, alu_cmd, pc_we, pc_src, mem_we, iord};

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mk(
        input logic ir, input logic rw, input logic [1:0] rd,
        input logic [1:0] m2r, input logic a, input logic [1:0] b,
        input logic [2:0] cmd, input logic pw, input logic [1:0] ps,
        input logic mw, input logic io);
        return {ir, rw, rd, m2r, a, b, cmd, pw, ps, mw, io};
    endfunction

    typedef enum int {C_R, C_I, C_LW, C_SW, C_BNE, C_J, C_JR, C_JAL, C_BAD} cls_t;

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) begin
            if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b101010) return C_R;
            if (fn == 6'b001000) return C_JR;
            return C_BAD;
        end
        case (op)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000101: return C_BNE;
            6'b001110, 6'b001000: return C_I;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default: return C_BAD;
        endcase
    endfunction

    function automatic int latency(input cls_t c);
        case (c)
            C_LW: return 5;
            C_R, C_I, C_SW: return 4;
            C_BAD: return 2;
            default: return 3;
        endcase
    endfunction

    // expected control word for cycle 'step' of an instruction of class c
    function automatic logic [16:0] expect_ctl(input cls_t c, input int step,
        input logic z, input logic [5:0] op, input logic [5:0] fn);
        logic [2:0] rc;
        rc = (fn == 6'b100010) ? 3'd1 : (fn == 6'b101010) ? 3'd3 : 3'd0;
        if (step == 0) return mk(1, 0, 0, 0, 0, 2'd2, 0, 1, 0, 0, 0);
        if (step == 1) return '0;
        case (c)
            C_R:
                return (step == 2) ? mk(0, 0, 0, 0, 1, 2'd1, rc, 0, 0, 0, 0)
                                   : mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            C_I:
                return (step == 2) ? mk(0, 0, 0, 0, 1, 0,
                                        (op == 6'b001110) ? 3'd2 : 3'd0, 0, 0, 0, 0)
                                   : mk(0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0);
            C_LW:
                return (step == 2) ? mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)
                     : (step == 3) ? mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)
                                   : mk(0, 1, 2'd1, 2'd1, 0, 0, 0, 0, 0, 0, 0);
            C_SW:
                return (step == 2) ? mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)
                                   : mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            C_BNE: return mk(0, 0, 0, 0, 1, 2'd1, 3'd1, !z, 2'd1, 0, 0);
            C_J:   return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0, 0);
            C_JR:  return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 0, 0);
            C_JAL: return mk(0, 1, 2'd2, 2'd2, 0, 0, 0, 1, 2'd2, 0, 0);
            default: return '0;
        endcase
    endfunction

    function automatic logic [63:0] cnt(input int v);
        return 64'(v % (1 << CNT_W));
    endfunction

    // run a whole instruction; entered and left just after a falling edge
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
        cls_t c;
        int n;
        c = classify(op, fn);
        n = latency(c);
        opcode = op;
        funct = fn;
        for (int s = 0; s < n; s++) begin
            zero = 1'($urandom);
            #1;
            check($sformatf("ctl op=%0h fn=%0h s=%0d", op, fn, s),
                  64'(ctl), 64'(expect_ctl(c, s, zero, op, fn)));
            check("cycle_count", 64'(cycle_count), cnt(ecyc));
            if (s == 0) check("instr_count", 64'(instr_count), cnt(einst));
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            check("illegal", 64'(illegal), 64'd0);
`endif
            @(negedge clk);
            ecyc++;
        end
        einst++;
    endtask

    task automatic pick(output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] ops [8];
        logic [5:0] fns [4];
        logic [5:0] bad [5];
        int k;
        ops = '{6'b100011, 6'b101011, 6'b000101, 6'b001110,
                6'b001000, 6'b000010, 6'b000011, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b101010, 6'b001000};
        bad = '{6'b111111, 6'b000100, 6'b100000, 6'b000001, 6'b001101};
        fn = 6'($urandom);
        k = $urandom_range(0, 9);
        if (k < 8) begin
            op = ops[k];
            if (k == 7) fn = fns[$urandom_range(0, 3)];
        end else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            op = 6'b000000;
            fn = 6'b100000;
`else
            if (k == 8) op = bad[$urandom_range(0, 4)];
            else begin
                op = 6'b000000;
                fn = 6'b000000;
            end
`endif
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_en", 64'({ir_we, reg_we, pc_we, mem_we}), 64'd0);
        check("rst_icnt", 64'(instr_count), 64'd0);
        check("rst_ccnt", 64'(cycle_count), 64'd0);
        reset = 1'b0;
        ecyc = 0;
        einst = 0;

        opcode = 6'b100011;
        funct = 6'd0;
        for (int s = 0; s < 4; s++) begin
            #1;
            check($sformatf("lw_pre s=%0d", s), 64'(ctl),
                  64'(expect_ctl(C_LW, s, zero, opcode, funct)));
            if (s < 3) @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        check("midrd_en", 64'({ir_we, reg_we, pc_we, mem_we}), 64'd0);
        check("midrd_icnt", 64'(instr_count), 64'd0);
        check("midrd_ccnt", 64'(cycle_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ecyc = 0;
        einst = 0;

        run_instr(6'b000000, 6'b100000);
        run_instr(6'b100011, 6'b000000);
        run_instr(6'b000101, 6'b000000);
        run_instr(6'b000011, 6'b000000);
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        run_instr(6'b111111, 6'b000000);
`endif
        for (int i = 0; i < 200; i++) begin
            pick(op, fn);
            run_instr(op, fn);
        end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        opcode = 6'b111111;
        for (int s = 0; s < 8; s++) begin
            zero = 1'($urandom);
            #1;
            if (s == 0)
                check("halt_fetch", 64'(ctl), 64'(expect_ctl(C_BAD, 0, zero, opcode, funct)));
            else begin
                check("halt_ctl", 64'(ctl), 64'd0);
                check("halt_illegal", 64'(illegal), (s >= 2) ? 64'd1 : 64'd0);
            end
            check("halt_ccnt", 64'(cycle_count), cnt(ecyc));
            check("halt_icnt", 64'(instr_count), cnt(einst));
            @(negedge clk);
            ecyc++;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
